instr_fetch_unit: RTL and testbench

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

---
 rtl/instr_fetch_unit.sv | 115 +++++++++++
 tb/tb_instr_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch/issue sequencer with a small write-only program memory.
// Optional build macro FETCH_LOOP_EN: wrap pc to 0 after the last address instead of halting.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | after reset; waiting for start, program memory writable
// S_FETCH | one-cycle read of mem[pc]
// S_ISSUE | instruction presented with instr_valid, waiting for instr_done
// S_HALT  | HALT opcode fetched or end of memory reached; waiting for start
module instr_fetch_unit #(
  parameter int INSTR_WIDTH = 20,
  parameter int ADDR_BITS   = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   prog_we,
  input  logic [ADDR_BITS-1:0]   prog_addr,
  input  logic [INSTR_WIDTH-1:0] prog_data,
  input  logic                   instr_done,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instr_valid,
  output logic [ADDR_BITS-1:0]   pc,
  output logic                   busy,
  output logic                   halted
);

  localparam int DEPTH = 1 << ADDR_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_HALT
  } state_t;

  state_t                 state_q, state_d;
  logic [ADDR_BITS-1:0]   pc_q, pc_d;
  logic [INSTR_WIDTH-1:0] instr_q, instr_d;
  logic [INSTR_WIDTH-1:0] mem_q [DEPTH];
  logic [INSTR_WIDTH-1:0] rd_data;
  logic                   mem_we;

  assign busy        = (state_q == S_FETCH) || (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);
  assign instr_valid = (state_q == S_ISSUE);
  assign instruction = instr_q;
  assign pc          = pc_q;

  // Memory has no reset so a program survives rst; it is frozen while running.
  assign mem_we  = prog_we && !busy;
  assign rd_data = mem_q[pc_q];

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      instr_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (rd_data == '0) begin
          state_d = S_HALT;
        end else begin
          instr_d = rd_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (instr_done) begin
          instr_d = '0;
          if (pc_q == ADDR_BITS'(DEPTH - 1)) begin
`ifdef FETCH_LOOP_EN
            pc_d    = '0;
            state_d = S_FETCH;
`else
            state_d = S_HALT;
`endif
          end else begin
            pc_d    = pc_q + ADDR_BITS'(1);
            state_d = S_FETCH;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        pc_d    = '0;
        instr_d = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized self-checking bench for instr_fetch_unit; the reference model walks
// a shadow copy of program memory and predicts the issue sequence and timing.
module tb_instr_fetch_unit;

  localparam int IW    = 20;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk        = 1'b0;
  logic          rst        = 1'b1;
  logic          start      = 1'b0;
  logic          prog_we    = 1'b0;
  logic [AW-1:0] prog_addr  = '0;
  logic [IW-1:0] prog_data  = '0;
  logic          instr_done = 1'b0;
  logic [IW-1:0] instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          halted;

  logic [IW-1:0] ref_mem [DEPTH];
  int n_chk  = 0;
  int n_fail = 0;

  instr_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_BITS(AW)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .prog_we     (prog_we),
    .prog_addr   (prog_addr),
    .prog_data   (prog_data),
    .instr_done  (instr_done),
    .instruction (instruction),
    .instr_valid (instr_valid),
    .pc          (pc),
    .busy        (busy),
    .halted      (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_valid"},  32'(instr_valid), 0);
    chk({tag, "_instr"},  32'(instruction), 0);
    chk({tag, "_pc"},     32'(pc), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_halted"}, 32'(halted), 0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    start      = 1'b0;
    prog_we    = 1'b0;
    instr_done = 1'b0;
    rst        = 1'b0;
    #1;
    chk_zero_outputs("rst");
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Only called while the unit is idle or halted, so every write lands.
  task automatic load(input int a, input logic [IW-1:0] d);
    @(negedge clk);
    prog_we   = 1'b1;
    prog_addr = AW'(a);
    prog_data = d;
    @(negedge clk);
    prog_we    = 1'b0;
    ref_mem[a] = d;
  endtask

  // ack_dly < 0 picks a random hold time; n_max > 0 stops after that many issues.
  task automatic run(input int ack_dly, input int n_max, input bit wr0, input logic [IW-1:0] wr0_data);
    int pc_m     = 0;
    int issued   = 0;
    int exp_w    = 2;
    bit exp_halt = 1'b0;
    int w;
    int d;
    @(negedge clk);
    start = 1'b1;
    if (wr0) begin
      prog_we    = 1'b1;
      prog_addr  = '0;
      prog_data  = wr0_data;
      ref_mem[0] = wr0_data;
    end
    forever begin
      if (!exp_halt && ref_mem[pc_m] == '0) exp_halt = 1'b1;
      w = 0;
      do begin
        @(negedge clk);
        w++;
        start      = 1'b0;
        prog_we    = 1'b0;
        instr_done = instr_valid ? 1'b0 : 1'($urandom_range(0, 1));
        if (!instr_valid) chk("not_issue_instr_zero", 32'(instruction), 0);
      end while (!instr_valid && !halted && w < 8);
      instr_done = 1'b0;
      chk("latency", w, exp_w);
      if (exp_halt) begin
        chk("halt_flag",  32'(halted), 1);
        chk("halt_valid", 32'(instr_valid), 0);
        chk("halt_pc",    32'(pc), pc_m);
        chk("halt_busy",  32'(busy), 0);
        break;
      end
      chk("issue_valid",  32'(instr_valid), 1);
      chk("issue_instr",  32'(instruction), 32'(ref_mem[pc_m]));
      chk("issue_pc",     32'(pc), pc_m);
      chk("issue_busy",   32'(busy), 1);
      chk("issue_halted", 32'(halted), 0);
      issued++;
      if (n_max > 0 && issued >= n_max) begin
        reset_pulse();
        break;
      end
      d = (ack_dly < 0) ? int'($urandom_range(0, 4)) : ack_dly;
      repeat (d) begin
        start     = 1'($urandom_range(0, 1));
        prog_we   = 1'($urandom_range(0, 1));
        prog_addr = '0;
        prog_data = IW'(20'hDB0F0);
        @(negedge clk);
        chk("hold_valid", 32'(instr_valid), 1);
        chk("hold_instr", 32'(instruction), 32'(ref_mem[pc_m]));
        chk("hold_pc",    32'(pc), pc_m);
      end
      start      = 1'b0;
      prog_we    = 1'b0;
      instr_done = 1'b1;
      if (pc_m == DEPTH - 1) begin
`ifdef FETCH_LOOP_EN
        pc_m  = 0;
        exp_w = 2;
`else
        exp_halt = 1'b1;
        exp_w    = 1;
`endif
      end else begin
        pc_m++;
        exp_w = 2;
      end
    end
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero_outputs("por");
    rst = 1'b1;

    load(0, IW'(20'h47000));
    load(1, IW'(20'h53000));
    load(2, IW'(20'h72001));
    load(3, IW'(20'h00000));
    run(3, 0, 1'b0, '0);
    run(10, 0, 1'b0, '0);

    // Reset in the middle of an issue, then re-run the intact program.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("pre_rst_valid", 32'(instr_valid), 1);
    repeat (2) @(negedge clk);
    reset_pulse();
    run(-1, 0, 1'b0, '0);

    // Zero written to address 0 on the same edge as start, from IDLE.
    reset_pulse();
    run(-1, 0, 1'b1, '0);
    load(0, IW'(20'h47000));

    for (int a = 0; a < DEPTH; a++) load(a, IW'($urandom_range(1, (1 << IW) - 1)));
    run(-1, 40, 1'b0, '0);

    for (int r = 0; r < 6; r++) begin
      for (int a = 0; a < DEPTH; a++) begin
        if ($urandom_range(0, 7) == 0) load(a, '0);
        else load(a, IW'($urandom_range(1, (1 << IW) - 1)));
      end
      run(-1, 40, 1'b0, '0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
